// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial nibble adder: slice width and FSM state encoding.
package serial_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder slice.
// Ports: a, b - addend nibbles; cin - carry in; s - sum nibble; co - carry out.
module nibble_add4
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] c;

    // Full-adder chain, bit 0 first.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(NIBBLE_W); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[NIBBLE_W];
    end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-word adder that reuses one 4-bit ripple slice, one nibble per cycle, LSB first.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   in_valid/in_ready  - operand handshake (op_a, op_b, cin captured on acceptance)
//   out_valid/out_ready- result handshake (sum, cout held until consumed)
//   busy               - high while an operation is in ADD or DONE
module serial_nibble_adder
    import serial_add_pkg::*;
#(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          in_ready_q, out_valid_q, busy_q;

    logic [31:0]         bit_off;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_co;

    // Select the current nibble of each captured operand.
    always_comb begin
        bit_off = 32'(idx_q) * 32'(NIBBLE_W);
        nib_a   = NIBBLE_W'(a_q >> bit_off);
        nib_b   = NIBBLE_W'(b_q >> bit_off);
    end

    nibble_add4 u_nibble_add4 (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q),
        .s   (nib_s),
        .co  (nib_co)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // sum was cleared on acceptance, so OR-ing each slice in is enough.
                sum_d   = sum_q | (W'(nib_s) << bit_off);
                carry_d = nib_co;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = nib_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and handshake flags; flags are registered images of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Self-checking bench: directed cases on a 4-nibble instance, randomized traffic on
// 1-, 4- and 8-nibble instances checked against {cout,sum} = a + b + cin.
module tb_serial_nibble_adder;

    localparam int unsigned NOPS   = 340;
    localparam int unsigned BUDGET = 30000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_d, rst_n_r;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Directed instance
    logic        d_iv, d_ir, d_ci, d_ov, d_or, d_co, d_busy;
    logic [15:0] d_a, d_b, d_s;

    serial_nibble_adder #(.NIBBLES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n_d),
        .in_valid  (d_iv),
        .in_ready  (d_ir),
        .op_a      (d_a),
        .op_b      (d_b),
        .cin       (d_ci),
        .out_valid (d_ov),
        .out_ready (d_or),
        .sum       (d_s),
        .cout      (d_co),
        .busy      (d_busy)
    );

    // Present operands at a negedge and return once in_ready is seen (accepted next edge).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci, output bit ok);
        d_a  = a;
        d_b  = b;
        d_ci = ci;
        d_iv = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (d_ir) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("issue_timeout", 64'(d_ir), 64'(1));
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [16:0] exp, input string tag);
        bit ok;
        d_or = 1'b1;
        issue(a, b, ci, ok);
        if (!ok) return;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            d_iv = 1'b0;
            if (k < 5) check({tag, "_early"}, 64'({d_ov, d_busy}), 64'(2'b01));
            else       check({tag, "_lat"}, 64'(d_ov), 64'(1));
        end
        check({tag, "_res"}, 64'({d_co, d_s}), 64'(exp));
        @(negedge clk);
        check({tag, "_drain"}, 64'({d_ov, d_ir}), 64'(2'b01));
    endtask

    initial begin : directed
        bit ok;
        rst_n_d = 1'b0;
        rst_n_r = 1'b0;
        d_iv = 1'b0;
        d_a  = '0;
        d_b  = '0;
        d_ci = 1'b0;
        d_or = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 64'({d_ov, d_ir, d_busy, d_co, d_s}), 64'({4'b0100, 16'h0}));
        rst_n_d = 1'b1;
        rst_n_r = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 17'h0_5555, "basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, "carry_chain");
        run_op(16'hFFFF, 16'h0000, 1'b1, 17'h1_0000, "cin_ripple");
        run_op(16'h0000, 16'h0000, 1'b1, 17'h0_0001, "cin_only");

        // Reset in the middle of ADD: the op must vanish.
        issue(16'h00FF, 16'h0F0F, 1'b1, ok);
        @(negedge clk);
        d_iv = 1'b0;
        @(negedge clk);
        rst_n_d = 1'b0;
        #1;
        check("rst_mid", 64'({d_ov, d_ir, d_busy, d_co, d_s}), 64'({4'b0100, 16'h0}));
        @(negedge clk);
        rst_n_d = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_after", 64'({d_ov, d_ir, d_busy}), 64'(3'b010));
        end

        // Backpressure: result held, new operands refused until the IDLE cycle.
        d_or = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0, ok);
        @(negedge clk);
        d_a = 16'hAAAA;
        d_b = 16'h5555;
        for (int i = 0; i < 20 && !d_ov; i++) @(negedge clk);
        check("bp_ov", 64'(d_ov), 64'(1));
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 64'({d_ov, d_ir, d_co, d_s}), 64'({3'b100, 16'h3333}));
            @(negedge clk);
        end
        d_or = 1'b1;
        @(negedge clk);
        check("bp_release", 64'({d_ov, d_ir, d_busy}), 64'(3'b010));
        @(negedge clk);
        d_iv = 1'b0;
        check("bp_accept", 64'(d_busy), 64'(1));
        for (int i = 0; i < 20 && !d_ov; i++) @(negedge clk);
        check("bp_new_res", 64'({d_ov, d_co, d_s}), 64'({2'b10, 16'hFFFF}));
        @(negedge clk);

        for (int c = 0; c < 40000; c++) begin
            if (g_rand[0].done && g_rand[1].done && g_rand[2].done) break;
            @(negedge clk);
        end
        check("rand_done", 64'({g_rand[0].done, g_rand[1].done, g_rand[2].done}), 64'(3'b111));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Randomized instances at 1, 4 and 8 nibbles.
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int unsigned N  = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        localparam int unsigned RW = 4 * N;

        logic          iv, ir, ci, ov, ordy, co, bz;
        logic [RW-1:0] a, b, s;
        logic [RW:0]   exp_q[$];
        bit            done = 1'b0;

        serial_nibble_adder #(.NIBBLES(N)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_r),
            .in_valid  (iv),
            .in_ready  (ir),
            .op_a      (a),
            .op_b      (b),
            .cin       (ci),
            .out_valid (ov),
            .out_ready (ordy),
            .sum       (s),
            .cout      (co),
            .busy      (bz)
        );

        initial begin : producer
            int unsigned sent = 0;
            iv = 1'b0;
            a  = '0;
            b  = '0;
            ci = 1'b0;
            wait (rst_n_r === 1'b1);
            while (sent < NOPS) begin
                @(negedge clk);
                iv = ($urandom_range(0, 3) != 0);
                a  = RW'({$urandom, $urandom});
                b  = RW'({$urandom, $urandom});
                ci = 1'($urandom);
                if ($urandom_range(0, 7) == 0) a = '1;
                if ($urandom_range(0, 7) == 0) b = '0;
                if (iv && ir) begin
                    exp_q.push_back((RW+1)'(a) + (RW+1)'(b) + (RW+1)'(ci));
                    sent++;
                end
            end
            @(negedge clk);
            iv = 1'b0;
        end

        initial begin : consumer
            int unsigned got = 0;
            int unsigned cyc = 0;
            logic [RW:0] e;
            string       tag;
            tag  = $sformatf("rand_n%0d", N);
            ordy = 1'b0;
            wait (rst_n_r === 1'b1);
            while (got < NOPS && cyc < BUDGET) begin
                @(negedge clk);
                cyc++;
                ordy = ($urandom_range(0, 2) != 0);
                if (ov && ordy) begin
                    check({tag, "_expected"}, 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check(tag, 64'({co, s}), 64'(e));
                    end
                    got++;
                end
            end
            check({tag, "_count"}, 64'(got), 64'(NOPS));
            done = 1'b1;
        end
    end

endmodule
